// File: rtl/avalon_pkg.sv
// avalon_pkg: shared defaults and flush FSM state type for the Avalon write buffer
package avalon_pkg;
    localparam int DEF_AW    = 13;
    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 8;
    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;
endpackage

// File: rtl/avalon_write_buffer_if.sv
// avalon_write_buffer_if: push side and head-of-queue handshake bundle
interface avalon_write_buffer_if #(
    parameter int AW = 13,
    parameter int DW = 32
) ();
    logic          w_ena;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic          out_ready;
    logic          out_valid;
    logic [AW-1:0] out_address;
    logic [DW-1:0] out_data;
    modport master (output w_ena, address, writedata, out_ready,
                    input  out_valid, out_address, out_data);
    modport slave  (input  w_ena, address, writedata, out_ready,
                    output out_valid, out_address, out_data);
endinterface

// File: rtl/buffer_regfile.sv
// buffer_regfile: DEPTH-entry storage, one synchronous write port, one asynchronous read port
module buffer_regfile #(
    parameter int DEPTH = 8,
    parameter int W     = 45
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    // contents are never reset; validity is tracked by the pointers and count
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/avalon_write_buffer.sv
// avalon_write_buffer: circular write buffer with overflow flag and flush-done handshake
module avalon_write_buffer
    import avalon_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                       clk,
    input  logic                       n_rst,
    avalon_write_buffer_if.slave       bus,
    input  logic                       flush,
    input  logic                       clear,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       done_calc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    state_t        state, state_n;
    assign full          = count == CW'(DEPTH);
    assign empty         = count == '0;
    assign bus.out_valid = !empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = bus.w_ena && (!full || pop);
    buffer_regfile #(.DEPTH(DEPTH), .W(AW + DW)) u_regfile (
        .clk   (clk),
        .we    (push && !clear),
        .waddr (wr_ptr),
        .wdata ({bus.address, bus.writedata}),
        .raddr (rd_ptr),
        .rdata ({bus.out_address, bus.out_data})
    );
    // pointers, occupancy and sticky overflow; clear outranks push and pop
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (bus.w_ena && !push) overflow <= 1'b1;
        end
    // flush FSM state register
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else state <= clear ? IDLE : state_n;
    // DONE only once the buffer is empty with nothing arriving in the same cycle
    always_comb begin
        state_n   = state;
        done_calc = 1'b0;
        state_n   = state == IDLE  ? (flush ? FLUSH : IDLE) :
                    state == FLUSH ? ((empty && !push) ? DONE : FLUSH) : IDLE;
        done_calc = state == DONE;
    end
endmodule

// File: tb/tb_avalon_write_buffer.sv
// tb_avalon_write_buffer: directed stimulus with a queue scoreboard checking every popped entry
module tb_avalon_write_buffer;
    import avalon_pkg::*;
    logic        clk, n_rst, flush, clear;
    logic        full, empty, overflow, done_calc;
    logic [3:0]  count;
    int          errors = 0;
    int          checks = 0;
    logic [44:0] exp_q[$];

    avalon_write_buffer_if #(.AW(13), .DW(32)) bus ();

    avalon_write_buffer dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus.slave),
        .flush     (flush),
        .clear     (clear),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .done_calc (done_calc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [12:0] a, input logic [31:0] d, input bit accepted);
        bus.w_ena     = 1'b1;
        bus.address   = a;
        bus.writedata = d;
        if (accepted) exp_q.push_back({a, d});
        tick();
        bus.w_ena = 1'b0;
    endtask

    // monitor: each cycle the DUT hands over its head entry, it must match the oldest expected push
    always @(negedge clk)
        if (n_rst && !clear && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got addr 0x%0h data 0x%0h expected no entry",
                         bus.out_address, bus.out_data);
            end else begin
                logic [44:0] e;
                e = exp_q.pop_front();
                if ({bus.out_address, bus.out_data} !== e) begin
                    errors++;
                    $display("FAIL pop_order: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             bus.out_address, bus.out_data, e[44:32], e[31:0]);
                end
            end
        end

    initial begin
        n_rst = 1'b0; flush = 1'b0; clear = 1'b0;
        bus.w_ena = 1'b0; bus.address = '0; bus.writedata = '0; bus.out_ready = 1'b0;
        tick();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done_calc, 0);
        n_rst = 1'b1;
        tick();

        // single push is visible the cycle after its edge
        push_one(13'h005, 32'hDEADBEEF, 1);
        check("single_valid", bus.out_valid, 1);
        check("single_addr", bus.out_address, 13'h005);
        check("single_data", bus.out_data, 32'hDEADBEEF);
        check("single_count", count, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("single_drained", empty, 1);

        // fill, overflow on the ninth push, then clear
        for (int i = 0; i < 8; i++) push_one(13'(i), 32'h1000 + 32'(i), 1);
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        check("fill_overflow", overflow, 0);
        push_one(13'h1FF, 32'hBAD0BAD0, 0);
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head_addr", bus.out_address, 13'h000);
        check("ovf_head_data", bus.out_data, 32'h1000);
        tick();
        check("ovf_sticky", overflow, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        check("clr_count", count, 0);
        check("clr_overflow", overflow, 0);
        check("clr_empty", empty, 1);

        // push and pop together while full: no drop, new entry comes out eighth
        for (int i = 0; i < 8; i++) push_one(13'h010 + 13'(i), 32'hA0 + 32'(i), 1);
        bus.out_ready = 1'b1;
        push_one(13'h099, 32'h0000_0099, 1);
        bus.out_ready = 1'b0;
        check("pp_count", count, 8);
        check("pp_overflow", overflow, 0);
        check("pp_head_addr", bus.out_address, 13'h011);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.out_ready = 1'b0;
        check("pp_empty", empty, 1);
        check("pp_scoreboard_left", 64'(exp_q.size()), 0);

        // flush with three entries, drained downstream
        for (int i = 0; i < 3; i++) push_one(13'h020 + 13'(i), 32'hC0DE0000 + 32'(i), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_count", count, 3);
        bus.out_ready = 1'b1;
        tick();
        check("fl_done_c2", done_calc, 0);
        tick();
        check("fl_done_c1", done_calc, 0);
        tick();
        check("fl_count0", count, 0);
        check("fl_done_c0", done_calc, 0);
        bus.out_ready = 1'b0;
        tick();
        check("fl_done_pulse", done_calc, 1);
        tick();
        check("fl_done_end", done_calc, 0);

        // flush while empty: pulse two edges later, second flush in DONE ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fe_done_e1", done_calc, 0);
        tick();
        check("fe_done_e2", done_calc, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fe_done_e3", done_calc, 0);
        tick();
        check("fe_ignored_a", done_calc, 0);
        tick();
        check("fe_ignored_b", done_calc, 0);

        // reset in the middle of a flush abandons it
        for (int i = 0; i < 4; i++) push_one(13'h030 + 13'(i), 32'h5A5A0000 + 32'(i), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("rf_count", count, 4);
        n_rst = 1'b0;
        #2;
        exp_q.delete();
        check("rf_empty", empty, 1);
        check("rf_valid", bus.out_valid, 0);
        check("rf_count0", count, 0);
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rf_no_done", done_calc, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/avalon_write_buffer.md
AVALON_WRITE_BUFFER -- requirements
Module: avalon_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of buffered entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 13, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 w_ena  input  1  push strobe; one entry per cycle asserted.
REQ-007 address  input  AW  word address accompanying the push.
REQ-008 writedata  input  DW  data accompanying the push.
REQ-009 flush  input  1  single-cycle request: signal done_calc once the buffer drains.
REQ-010 clear  input  1  synchronous clear of buffer, flags and FSM.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_valid  output  1  head entry present.
REQ-013 out_address  output  AW  head entry address.
REQ-014 out_data  output  DW  head entry data.
REQ-015 full  output  1  count == DEPTH.
REQ-016 empty  output  1  count == 0.
REQ-017 count  output  clog2(DEPTH)+1  occupancy.
REQ-018 overflow  output  1  sticky: a push was dropped.
REQ-019 done_calc  output  1  one-cycle pulse: flushed data fully consumed.

Function
REQ-020 Storage SHALL be circular, DEPTH entries of {address, writedata}, write and read pointers clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-021 Push SHALL occur when w_ena=1 and (full=0, or out_valid=1 and out_ready=1 in the same cycle).
REQ-022 Push while full without a simultaneous pop SHALL drop the entry, leave storage and count unchanged, and set overflow=1.
REQ-023 Pop SHALL occur when out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 out_valid SHALL equal !empty; out_address/out_data SHALL show the entry at the read pointer, stable until popped.
REQ-026 Latency: an entry pushed at edge N SHALL be visible on out_* in the cycle after edge N when the buffer was empty.
REQ-027 Order SHALL be strict FIFO; no entry reordered or duplicated.
REQ-028 FSM states SHALL be IDLE, FLUSH, DONE.
REQ-029 IDLE -> FLUSH on flush=1; FLUSH -> DONE when count==0 (including the cycle entered if already empty at the next edge); DONE -> IDLE unconditionally.
REQ-030 done_calc SHALL be 1 only in DONE, exactly one cycle per flush.
REQ-031 Pushes SHALL be accepted normally in FLUSH; DONE SHALL wait until the buffer is empty, including those entries.
REQ-032 flush in FLUSH or DONE SHALL be ignored.
REQ-033 clear=1 SHALL, at the next edge, zero pointers and count, clear overflow, return FSM to IDLE, and take priority over push, pop and flush in that cycle.
REQ-034 overflow SHALL clear only on clear or reset.

Reset
REQ-035 On n_rst=0: pointers=0, count=0, empty=1, full=0, out_valid=0, overflow=0, done_calc=0, FSM=IDLE; storage contents need not reset.
REQ-036 Reset mid-flush SHALL abandon the flush with no done_calc pulse.

Structure
REQ-037 Shared package avalon_pkg SHALL hold AW, DW, DEPTH defaults and the IDLE/FLUSH/DONE enum type.
REQ-038 Storage SHALL be a sub-module buffer_regfile (DEPTH x (AW+DW), one write port, one asynchronous read port); pointer, count and FSM logic stay in the top.

Verification
REQ-039 Push addr 0x005/data 0xDEADBEEF, out_ready=0 -> next cycle out_valid=1, out_address=0x005, out_data=0xDEADBEEF, count=1.
REQ-040 Push 8 entries, out_ready=0, then ninth push -> full=1, count=8, overflow=1, head unchanged; clear -> count=0, overflow=0.
REQ-041 Full buffer, w_ena=1 and out_ready=1 same cycle -> count stays 8, overflow=0, new entry emerges 8th after wrap.
REQ-042 Push 3, flush pulse, drain with out_ready=1 -> done_calc high exactly one cycle after count reaches 0, FSM back to IDLE.
REQ-043 Flush with buffer empty -> done_calc pulse two edges later; second flush during DONE ignored.
REQ-044 Assert n_rst during FLUSH with count=4 -> empty=1, out_valid=0, no done_calc after release.
